ultra_scan_sched: RTL and testbench
===================================

Name: ultra_scan_sched

Overview:
- Round-robin scheduler for N ultrasonic rangers sharing one measurement engine.
- Per sensor, in order: fires the trigger pulse, times the echo pulse, reports a tagged result, then waits a settle gap before the next sensor.
- Sits between the sensor pins and the AXI register/IP wrapper that software reads.

Parameters:
N_SENSORS, 4, number of rangers (1..8)
TRIG_CYCLES, 2000, trigger high time in clk cycles (20 us @ 100 MHz)
ECHO_TIMEOUT, 3000000, max cycles from end of trigger to echo fall (30 ms)
GAP_CYCLES, 6000000, quiet time between pings to let echoes die (60 ms)
DIST_W, 22, width of result / cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  scanning allowed
sensor_mask  in  N_SENSORS  1 = sensor participates in the scan
echo  in  N_SENSORS  raw asynchronous echo pins
trig  out  N_SENSORS  trigger pins, at most one high at a time
dist_valid  out  1  one-cycle result strobe
dist_data  out  DIST_W  echo high time (cycles, or cm with the optional feature)
dist_id  out  $clog2(N_SENSORS) (min 1)  sensor index of the result
dist_timeout  out  1  qualifies dist_valid: no or overlong echo
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, last-served pointer = N_SENSORS-1 (so sensor 0 is served first), counters 0.
- echo passes through 2-FF synchronizers, plus one registered copy for edge detection. Pin-to-edge latency is 3 cycles.
- IDLE: if enable && |sensor_mask, select the first set mask bit searching upward from last+1 with wrap-around. Record it as sel and go to TRIG. Otherwise stay.
- TRIG: trig[sel]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE with the timeout counter cleared.
- WAIT_RISE: wait for a synced echo[sel] rising edge, then go to MEASURE with count=1.
  - An echo already high on entry is not a rise; it must fall and rise again.
- MEASURE: count++ each cycle echo[sel] is high (count saturates at all-ones). On the falling edge, emit the result.
- Timeout: one counter runs through WAIT_RISE and MEASURE. When it reaches ECHO_TIMEOUT, emit the result with dist_timeout=1 and dist_data=all-ones.
- Emit: dist_valid=1 for one cycle, the cycle after the fall is detected. dist_id=sel. dist_data/dist_id/dist_timeout hold until the next emit. Update last=sel, then go to GAP.
- GAP: wait GAP_CYCLES, then IDLE.
- enable drops mid-ping: the current ping completes and emits, GAP is skipped, return to IDLE.
- sensor_mask is sampled only in IDLE; changes mid-ping affect the next selection only.
- Single enabled sensor: it is re-served every round.
- Mask all-zero: stay in IDLE, busy=0.
- Echoes on non-selected sensors are ignored.
- rst mid-operation: trig drops in the same cycle the reset is registered, and the ping is discarded with no emit.

Optional Feature:
- Macro: ULTRA_CM_CONV_EN.
- Defined: dist_data = (count * CM_RECIP) >> 24, where CM_RECIP = round(2^24 / 5800) for 100 MHz (58 us per cm). One extra register stage, so dist_valid comes 1 cycle later. Timeout still reports all-ones.
- Undefined: dist_data is the raw cycle count and no multiplier is inferred.

Decomposition:
- Package ultra_pkg holds:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GAP);
  - the CM_RECIP constant;
  - a next_enabled() round-robin function.
- One sub-module, ultra_sync2: a per-bit 2-FF synchronizer, instantiated N_SENSORS wide.

Test Plan (sim params: N_SENSORS=4, TRIG_CYCLES=10, ECHO_TIMEOUT=200, GAP_CYCLES=20):
1. mask=4'b1111, enable=1, each sensor echoes 50 cycles after trig fall for 40 cycles -> trig pulses 10 cycles each in order 0,1,2,3,0; dist_id follows; dist_data=40; dist_timeout=0.
2. mask=4'b1010 -> only sensors 1,3 pinged, alternating; trig[0], trig[2] never high.
3. Sensor 2 never echoes -> dist_valid with id=2, timeout=1, data=all-ones 200 cycles after trig fall; the scan continues to sensor 3.
4. echo[sel] held high from before TRIG, falls at cycle 30, rises at 40, falls at 65 -> dist_data=25.
5. enable dropped during MEASURE -> result still emitted; busy=0 on the next cycle; no further trig.
6. rst pulsed during TRIG -> trig=0 the next cycle, no dist_valid; after release, sensor 0 is served first.

Source files
------------

// File: rtl/ultra_pkg.sv
// Shared types and helpers for the ultrasonic ranger scheduler.
package ultra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  // round(2^24 / 5800): cycles-to-cm reciprocal at 100 MHz (58 us per cm)
  localparam int unsigned CM_RECIP    = 2893;
  localparam int unsigned MAX_SENSORS = 8;

  // First set mask bit strictly after 'last', wrapping within n sensors.
  function automatic logic [2:0] next_enabled(input logic [7:0] mask,
                                              input logic [2:0] last,
                                              input int         n);
    logic [2:0] pick;
    int         idx;
    pick = last;
    for (int i = 8; i >= 1; i--) begin
      if (i <= n) begin
        idx = (int'(last) + i) % n;
        if (mask[3'(idx)]) pick = 3'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ultra_scan_sched_if.sv
// Pin and result bus between the ranger scheduler and its register wrapper.
interface ultra_scan_sched_if #(
  parameter int unsigned N_SENSORS = 4,
  parameter int unsigned DIST_W    = 22
);
  localparam int unsigned ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  logic                 enable;
  logic [N_SENSORS-1:0] sensor_mask;
  logic [N_SENSORS-1:0] echo;
  logic [N_SENSORS-1:0] trig;
  logic                 dist_valid;
  logic [DIST_W-1:0]    dist_data;
  logic [ID_W-1:0]      dist_id;
  logic                 dist_timeout;
  logic                 busy;

  modport master (
    output enable, sensor_mask, echo,
    input  trig, dist_valid, dist_data, dist_id, dist_timeout, busy
  );

  modport slave (
    input  enable, sensor_mask, echo,
    output trig, dist_valid, dist_data, dist_id, dist_timeout, busy
  );
endinterface

// File: rtl/ultra_sync2.sv
// Single-bit two-flop synchronizer for an asynchronous echo pin.
module ultra_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ultra_scan_sched.sv
// Round-robin trigger/echo scheduler for N ultrasonic rangers on one timer.
// Optional macro ULTRA_CM_CONV_EN: report centimetres (one extra output stage).
module ultra_scan_sched
  import ultra_pkg::*;
#(
  parameter int unsigned N_SENSORS    = 4,
  parameter int unsigned TRIG_CYCLES  = 2000,
  parameter int unsigned ECHO_TIMEOUT = 3000000,
  parameter int unsigned GAP_CYCLES   = 6000000,
  parameter int unsigned DIST_W       = 22
) (
  input  logic               clk,
  input  logic               rst,
  ultra_scan_sched_if.slave  bus
);

  localparam int unsigned ID_W    = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int unsigned SEQ_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(ECHO_TIMEOUT + 1);

  logic [N_SENSORS-1:0] echo_s;
  logic [N_SENSORS-1:0] echo_d;

  for (genvar g = 0; g < int'(N_SENSORS); g++) begin : g_sync
    ultra_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.echo[g]),
      .q   (echo_s[g])
    );
  end

  // Delayed copy of the synchronized echoes for edge detection
  always_ff @(posedge clk) begin
    if (rst) echo_d <= '0;
    else     echo_d <= echo_s;
  end

  state_t               state;
  logic [ID_W-1:0]      sel;
  logic [ID_W-1:0]      last;
  logic [SEQ_W-1:0]     seq_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [DIST_W-1:0]    count;
  logic [N_SENSORS-1:0] trig_q;
  logic                 busy_q;
  logic                 emit_valid;
  logic [DIST_W-1:0]    emit_data;
  logic [ID_W-1:0]      emit_id;
  logic                 emit_timeout;

  logic            echo_sel_c;
  logic            rise_c;
  logic            fall_c;
  logic            in_ping_c;
  logic            tmo_hit_c;
  logic            emit_c;
  logic [ID_W-1:0] pick_c;

  assign echo_sel_c = echo_s[sel];
  assign rise_c     = echo_sel_c & ~echo_d[sel];
  assign fall_c     = ~echo_sel_c & echo_d[sel];
  assign in_ping_c  = (state == WAIT_RISE) || (state == MEASURE);
  assign tmo_hit_c  = in_ping_c && (tmo_cnt == TMO_W'(ECHO_TIMEOUT - 1));
  assign emit_c     = tmo_hit_c || ((state == MEASURE) && fall_c);
  assign pick_c     = ID_W'(next_enabled(8'(bus.sensor_mask), 3'(last), int'(N_SENSORS)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      last         <= ID_W'(N_SENSORS - 1);
      seq_cnt      <= '0;
      tmo_cnt      <= '0;
      count        <= '0;
      trig_q       <= '0;
      busy_q       <= 1'b0;
      emit_valid   <= 1'b0;
      emit_data    <= '0;
      emit_id      <= '0;
      emit_timeout <= 1'b0;
    end else begin
      emit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && |bus.sensor_mask) begin
            sel     <= pick_c;
            trig_q  <= N_SENSORS'(1) << pick_c;
            seq_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= TRIG;
          end
        end
        TRIG: begin
          if (seq_cnt == SEQ_W'(TRIG_CYCLES - 1)) begin
            trig_q  <= '0;
            tmo_cnt <= '0;
            state   <= WAIT_RISE;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        WAIT_RISE: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (rise_c) begin
            count <= DIST_W'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (echo_sel_c && (count != '1)) count <= count + DIST_W'(1);
        end
        GAP: begin
          if (seq_cnt == SEQ_W'(GAP_CYCLES - 1)) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Result emit overrides the per-state updates above
      if (emit_c) begin
        emit_valid   <= 1'b1;
        emit_data    <= tmo_hit_c ? '1 : count;
        emit_id      <= sel;
        emit_timeout <= tmo_hit_c;
        last         <= sel;
        seq_cnt      <= '0;
        if (bus.enable) begin
          state <= GAP;
        end else begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      end
    end
  end

  assign bus.trig = trig_q;
  assign bus.busy = busy_q;

`ifdef ULTRA_CM_CONV_EN
  logic              out_valid;
  logic [DIST_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic              out_timeout;

  // Cycles-to-centimetre scaling by fixed-point reciprocal
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
      out_timeout <= 1'b0;
    end else begin
      out_valid <= emit_valid;
      if (emit_valid) begin
        out_data    <= emit_timeout ? '1
                     : DIST_W'((64'(emit_data) * 64'(CM_RECIP)) >> 24);
        out_id      <= emit_id;
        out_timeout <= emit_timeout;
      end
    end
  end

  assign bus.dist_valid   = out_valid;
  assign bus.dist_data    = out_data;
  assign bus.dist_id      = out_id;
  assign bus.dist_timeout = out_timeout;
`else
  assign bus.dist_valid   = emit_valid;
  assign bus.dist_data    = emit_data;
  assign bus.dist_id      = emit_id;
  assign bus.dist_timeout = emit_timeout;
`endif

endmodule

// File: tb/tb_ultra_scan_sched.sv
// Bench for ultra_scan_sched: table and random scans against a round-robin model.
module tb_ultra_scan_sched;

  localparam int N    = 4;
  localparam int TRIG = 10;
  localparam int TMO  = 200;
  localparam int GAP  = 20;
  localparam int DW   = 22;
  localparam int ALL1 = (1 << DW) - 1;
`ifdef ULTRA_CM_CONV_EN
  localparam int CONV_LAT = 1;
`else
  localparam int CONV_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #5 clk = ~clk;

  ultra_scan_sched_if #(.N_SENSORS(N), .DIST_W(DW)) bus ();

  ultra_scan_sched #(
    .N_SENSORS    (N),
    .TRIG_CYCLES  (TRIG),
    .ECHO_TIMEOUT (TMO),
    .GAP_CYCLES   (GAP),
    .DIST_W       (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int id;
    int data;
    int to;
    int cyc;
  } res_t;

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][7:0] w;
    logic [2:0]      n;
    logic [4:0][1:0] ids;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   multi_hot = 0;
  res_t got_q[$];
  int   trig_id_q[$];
  int   trig_len_q[$];
  int   trig_fall_q[$];
  int   resp_w[4];
  int   resp_delay = 50;
  bit   resp_on = 1'b0;
  int   exp_ids[8];

  // Output monitor: trigger pulses and result strobes
  initial begin
    logic [3:0] prev_t;
    int         len;
    prev_t = '0;
    len    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((bus.trig & (bus.trig - 4'd1)) != 4'd0) multi_hot++;
      if (bus.trig != 4'd0) len++;
      for (int s = 0; s < N; s++) begin
        if (prev_t[s] && !bus.trig[s]) begin
          trig_id_q.push_back(s);
          trig_len_q.push_back(len);
          trig_fall_q.push_back(cyc);
          len = 0;
        end
      end
      if (bus.dist_valid)
        got_q.push_back('{id: int'(bus.dist_id), data: int'(bus.dist_data),
                          to: int'(bus.dist_timeout), cyc: cyc});
      prev_t = bus.trig;
    end
  end

  // Sensor model: echo of resp_w cycles, resp_delay cycles after its trigger ends
  initial begin
    int         since[4];
    logic [3:0] prev_t;
    for (int s = 0; s < N; s++) since[s] = -1;
    prev_t = '0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < N; s++) begin
        if (prev_t[s] && !bus.trig[s] && !rst) since[s] = 0;
        else if (since[s] >= 0) since[s]++;
        if (since[s] > 1000) since[s] = -1;
      end
      if (resp_on)
        for (int s = 0; s < N; s++)
          bus.echo[s] = (resp_w[s] > 0) && (since[s] >= resp_delay) &&
                        (since[s] < resp_delay + resp_w[s]);
      prev_t = bus.trig;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int exp_dist(input int w);
`ifdef ULTRA_CM_CONV_EN
    return int'((longint'(w) * 2893) >> 24);
`else
    return w;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    tick(3);
    got_q.delete();
    trig_id_q.delete();
    trig_len_q.delete();
    trig_fall_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (got_q.size() < n) timeout_fail(name);
  endtask

  task automatic wait_trig_falls(input int n, input int budget, input string name);
    int k = 0;
    while (trig_id_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (trig_id_q.size() < n) timeout_fail(name);
  endtask

  // Round-robin order from the scheduling rule: next set bit after the last served
  task automatic model_ids(input logic [3:0] mask, input int n);
    int last = N - 1;
    for (int i = 0; i < n; i++) begin
      do last = (last + 1) % N; while (!mask[2'(last)]);
      exp_ids[i] = last;
    end
  endtask

  task automatic run_trial(input string name, input logic [3:0] mask, input int n);
    int bad = 0;
    do_reset();
    bus.sensor_mask = mask;
    resp_on = 1'b1;
    bus.enable = 1'b1;
    wait_results(n, 5000, {name, "_wait"});
    bus.enable = 1'b0;
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      int id     = exp_ids[i];
      int exp_to = (resp_w[id] == 0) ? 1 : 0;
      check({name, "_id"}, got_q[i].id, id);
      check({name, "_timeout"}, got_q[i].to, exp_to);
      check({name, "_data"}, got_q[i].data, exp_to ? ALL1 : exp_dist(resp_w[id]));
      if (i < trig_id_q.size()) begin
        check({name, "_trig_id"}, trig_id_q[i], id);
        check({name, "_trig_len"}, trig_len_q[i], TRIG);
        if (exp_to == 1)
          check({name, "_tmo_latency"}, got_q[i].cyc - trig_fall_q[i], TMO + CONV_LAT);
      end
    end
    foreach (trig_id_q[k]) if (!mask[2'(trig_id_q[k])]) bad++;
    check({name, "_trig_masked"}, bad, 0);
  endtask

  vec_t vt[5];

  initial begin
    int nres;
    int k;
    bus.enable      = 1'b0;
    bus.sensor_mask = '0;
    bus.echo        = '0;
    for (int s = 0; s < N; s++) resp_w[s] = 40;

    vt[0].mask = 4'b1111; vt[0].w = {8'd40, 8'd40, 8'd40, 8'd40}; vt[0].n = 3'd5;
    vt[0].ids  = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    vt[1].mask = 4'b1010; vt[1].w = {8'd40, 8'd40, 8'd40, 8'd40}; vt[1].n = 3'd4;
    vt[1].ids  = {2'd0, 2'd3, 2'd1, 2'd3, 2'd1};
    vt[2].mask = 4'b0100; vt[2].w = {8'd40, 8'd40, 8'd40, 8'd40}; vt[2].n = 3'd3;
    vt[2].ids  = {2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
    vt[3].mask = 4'b1111; vt[3].w = {8'd40, 8'd0, 8'd40, 8'd40};  vt[3].n = 3'd4;
    vt[3].ids  = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    vt[4].mask = 4'b1001; vt[4].w = {8'd15, 8'd40, 8'd40, 8'd90}; vt[4].n = 3'd3;
    vt[4].ids  = {2'd0, 2'd0, 2'd0, 2'd3, 2'd0};

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_trig", int'(bus.trig), 0);
    check("rst_valid", int'(bus.dist_valid), 0);
    check("rst_data", int'(bus.dist_data), 0);
    check("rst_id", int'(bus.dist_id), 0);
    check("rst_timeout", int'(bus.dist_timeout), 0);
    check("rst_busy", int'(bus.busy), 0);

    // Empty mask: stays idle
    do_reset();
    bus.sensor_mask = 4'b0000;
    bus.enable = 1'b1;
    tick(40);
    check("zero_mask_busy", int'(bus.busy), 0);
    check("zero_mask_trig", int'(bus.trig), 0);
    check("zero_mask_results", got_q.size(), 0);

    // Table-driven scans
    resp_delay = 50;
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < N; s++) resp_w[s] = int'(vt[i].w[s]);
      for (int j = 0; j < 5; j++) exp_ids[j] = int'(vt[i].ids[j]);
      run_trial($sformatf("vec%0d", i), vt[i].mask, int'(vt[i].n));
    end

    // Randomized scans against the round-robin model
    for (int t = 0; t < 6; t++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      resp_delay = int'($urandom_range(3, 80));
      for (int s = 0; s < N; s++)
        resp_w[s] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(5, 100));
      model_ids(m, 5);
      run_trial($sformatf("rand%0d", t), m, 5);
    end

    // Echo already high on entry must fall and rise again
    resp_delay = 50;
    for (int s = 0; s < N; s++) resp_w[s] = 40;
    do_reset();
    resp_on = 1'b0;
    bus.echo = 4'b0001;
    bus.sensor_mask = 4'b0001;
    bus.enable = 1'b1;
    wait_trig_falls(1, 100, "prehigh_trig");
    tick(30);
    bus.echo = 4'b0000;
    tick(10);
    bus.echo = 4'b0001;
    tick(25);
    bus.echo = 4'b0000;
    wait_results(1, 300, "prehigh_wait");
    bus.enable = 1'b0;
    if (got_q.size() >= 1) begin
      check("prehigh_data", got_q[0].data, exp_dist(25));
      check("prehigh_timeout", got_q[0].to, 0);
      check("prehigh_id", got_q[0].id, 0);
    end

    // Enable dropped while measuring: emit, skip the gap, stop
    do_reset();
    resp_on = 1'b1;
    bus.sensor_mask = 4'b0001;
    bus.enable = 1'b1;
    wait_trig_falls(1, 100, "endrop_trig");
    tick(60);
    bus.enable = 1'b0;
    wait_results(1, 200, "endrop_wait");
    if (got_q.size() >= 1) check("endrop_data", got_q[0].data, exp_dist(40));
    tick(1);
    check("endrop_busy", int'(bus.busy), 0);
    tick(100);
    check("endrop_no_trig", trig_id_q.size(), 1);
    check("endrop_no_result", got_q.size(), 1);

    // Reset during a trigger pulse discards the ping
    do_reset();
    bus.sensor_mask = 4'b1111;
    bus.enable = 1'b1;
    wait_results(1, 400, "rstmid_first");
    k = 0;
    while (!bus.trig[1] && k < 100) begin
      tick(1);
      k++;
    end
    if (!bus.trig[1]) timeout_fail("rstmid_trig1");
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rstmid_trig_drop", int'(bus.trig), 0);
    tick(2);
    nres = got_q.size();
    rst = 1'b0;
    k = 0;
    while (bus.trig == 4'd0 && k < 50) begin
      tick(1);
      k++;
    end
    check("rstmid_restart", int'(bus.trig), 1);
    check("rstmid_no_emit", got_q.size(), nres);
    check("rstmid_result_count", nres, 1);
    bus.enable = 1'b0;

    check("trig_onehot", multi_hot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
